// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 17-bit ISA.
// Holds the PC and issues single-outstanding requests to a variable-latency
// instruction memory. Presents one instruction plus its PC to decode, honours
// decode stalls through a one-entry skid buffer, and redirects on taken branches.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr      -> one-cycle request pulse and word address
//   imem_rdata/imem_valid   <- returned word
//   stall, pc_src, br_offset <- decode back-pressure and branch redirect
//   instr_out/pc_out/instr_valid -> instruction presented to decode
// Optional (macro FETCH_PERF_CNT_EN): fetch_cnt[31:0], squash_cnt[15:0].
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 17,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                OFF_W    = 11
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               pc_src,
    input  logic [OFF_W-1:0]   br_offset,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [15:0]        squash_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HELD,
        S_SQUASH
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;
    logic               deliver;
    logic               squash_word;

    // A branch can only be taken while decode actually holds an instruction.
    assign redirect = pc_src & valid_q;
    assign target   = pc_out_q
                    + {{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign pc_inc   = pc_q + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_out_d     = pc_out_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        deliver      = 1'b0;
        squash_word  = 1'b0;

        // Decode takes the current word unless something replaces it below.
        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_valid) begin
                    pc_d = pc_inc;
                    if (!valid_q || !stall) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        deliver  = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!stall) begin
                    instr_d  = skid_instr_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    deliver  = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_SQUASH: begin
                if (imem_valid) begin
                    squash_word = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over stall and over a word returning this cycle.
        if (redirect) begin
            pc_d         = target;
            pc_out_d     = pc_out_q;
            instr_d      = instr_q;
            valid_d      = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            deliver      = 1'b0;
            squash_word  = 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    if (imem_valid) begin
                        squash_word = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_SQUASH;
                    end
                end
                S_REQ:    state_d = S_SQUASH;
                S_SQUASH: begin
                    squash_word = imem_valid;
                    state_d     = imem_valid ? S_REQ : S_SQUASH;
                end
                default:  state_d = S_REQ;
            endcase
        end

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            pc_out_q     <= '0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            pc_out_q     <= pc_out_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [15:0] scnt_q, scnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        if (deliver && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + 32'd1;
        end
        if (squash_word && (scnt_q != '1)) begin
            scnt_d = scnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign fetch_cnt  = fcnt_q;
    assign squash_cnt = scnt_q;
`else
    logic unused_perf;
    assign unused_perf = deliver ^ squash_word;
`endif

endmodule
